// File: rtl/data_path_muxs_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM states, the
// per-cycle control bundle and the load-use hazard detector.
package data_path_muxs_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic en_if_id;
    logic en_id_ex;
    logic en_ex_mem;
    logic en_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_RUN    = 8'b11111_000;
  localparam ctrl_out_t CTRL_FREEZE = 8'b00000_000;
  localparam ctrl_out_t CTRL_RESET  = 8'b00000_111;
  localparam ctrl_out_t CTRL_REDIR  = 8'b11111_111;
  localparam ctrl_out_t CTRL_LDUSE  = 8'b00111_010;
  localparam ctrl_out_t CTRL_FMISS  = 8'b01111_100;

  // $0 never creates a dependency; rt only counts when the instruction reads it.
  function automatic logic load_use_hazard(
    input logic       load,
    input logic [4:0] dest,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return load && (dest != 5'd0) && ((dest == rs) || (uses_rt && (dest == rt)));
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter: synchronous clear, enable-gated increment,
// wraps modulo 2^CNT_W.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count
  always_comb begin
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the five-stage pipeline: combinational latch
// enables/flushes from state + hazards, plus stall and redirect counters.
module pipeline_controller
  import data_path_muxs_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req_EX_MEM,
  input  logic             load_ID_EX,
  input  logic [4:0]       reg_dest_ID_EX,
  input  logic [4:0]       rs_IF_ID,
  input  logic [4:0]       rt_IF_ID,
  input  logic             uses_rt_IF_ID,
  input  logic             redirect_EX_MEM,
  input  logic             halt_MEM_WB,
  output logic             pc_en,
  output logic             en_IF_ID,
  output logic             en_ID_EX,
  output logic             en_EX_MEM,
  output logic             en_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_t state_q;
  ctrl_state_t state_d;
  ctrl_out_t   ctrl_s;
  logic        evaluate_s;
  logic        from_run_s;
  logic        flush_inc_s;
  logic        stall_inc_s;
  logic        hazard_s;

  assign hazard_s = load_use_hazard(load_ID_EX, reg_dest_ID_EX, rs_IF_ID,
                                    rt_IF_ID, uses_rt_IF_ID);

  // control decode: state selects freeze/evaluate, then hazards by priority
  always_comb begin
    ctrl_s      = CTRL_RUN;
    state_d     = state_q;
    evaluate_s  = 1'b0;
    from_run_s  = 1'b0;
    flush_inc_s = 1'b0;
    if (RST) begin
      ctrl_s  = CTRL_RESET;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          evaluate_s = 1'b1;
          from_run_s = 1'b1;
        end
        DWAIT: begin
          if (dhit) begin
            evaluate_s = 1'b1;
            state_d    = RUN;
          end else begin
            ctrl_s = CTRL_FREEZE;
          end
        end
        HALTED:  ctrl_s = CTRL_FREEZE;
        default: begin
          ctrl_s  = CTRL_FREEZE;
          state_d = RUN;
        end
      endcase
    end
    // halt and memory wait are only meaningful when arriving from RUN
    if (evaluate_s) begin
      if (from_run_s && halt_MEM_WB) begin
        ctrl_s  = CTRL_FREEZE;
        state_d = HALTED;
      end else if (from_run_s && dmem_req_EX_MEM && !dhit) begin
        ctrl_s  = CTRL_FREEZE;
        state_d = DWAIT;
      end else if (redirect_EX_MEM) begin
        ctrl_s      = CTRL_REDIR;
        flush_inc_s = 1'b1;
      end else if (hazard_s) begin
        ctrl_s = CTRL_LDUSE;
      end else if (!ihit) begin
        ctrl_s = CTRL_FMISS;
      end else begin
        ctrl_s = CTRL_RUN;
      end
    end else begin
      flush_inc_s = 1'b0;
    end
  end

  assign stall_inc_s = !RST && (state_q != HALTED) && !ctrl_s.pc_en;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_en        = ctrl_s.pc_en;
  assign en_IF_ID     = ctrl_s.en_if_id;
  assign en_ID_EX     = ctrl_s.en_id_ex;
  assign en_EX_MEM    = ctrl_s.en_ex_mem;
  assign en_MEM_WB    = ctrl_s.en_mem_wb;
  assign flush_IF_ID  = ctrl_s.flush_if_id;
  assign flush_ID_EX  = ctrl_s.flush_id_ex;
  assign flush_EX_MEM = ctrl_s.flush_ex_mem;
  assign halt         = (state_q == HALTED);

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (CLK),
    .clr_i (RST),
    .inc_i (stall_inc_s),
    .cnt_o (stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (CLK),
    .clr_i (RST),
    .inc_i (flush_inc_s),
    .cnt_o (flush_cnt)
  );

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the five-stage pipeline. Watches cache handshakes, load-use dependencies, resolved branches and halt, then drives the PC enable and the per-latch enable/flush controls for IF/ID, ID/EX, EX/MEM and MEM/WB. It works alongside the forwarding unit, covering the hazards that forwarding cannot resolve: load-use, memory wait, fetch miss and redirect. It also keeps stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- dmem_req_EX_MEM  in  1  EX/MEM holds LW, SW, LL or SC
- load_ID_EX  in  1  ID/EX holds LW or LL
- reg_dest_ID_EX  in  5  destination register of the ID/EX instruction
- rs_IF_ID, rt_IF_ID  in  5 each  source registers of the IF/ID instruction
- uses_rt_IF_ID  in  1  rt is a read operand of the IF/ID instruction
- redirect_EX_MEM  in  1  taken branch or jump resolved in EX/MEM
- halt_MEM_WB  in  1  HALT has reached MEM/WB
- pc_en  out  1  PC register loads its next value
- en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB  out  1 each  latch captures its input
- flush_IF_ID, flush_ID_EX, flush_EX_MEM  out  1 each  latch loads a bubble (all zeros) instead of its input
- halt  out  1  sticky halt flag
- stall_cnt  out  CNT_W  count of cycles in which pc_en=0 while not halted
- flush_cnt  out  CNT_W  count of redirects taken

## Operation
- FSM states: RUN, DWAIT, HALTED.
- A flush takes effect only when the corresponding enable is 1.
- Default in RUN: every enable is 1, every flush is 0.
- Evaluation in RUN uses strict priority, highest first:
  1. **halt_MEM_WB**
     - All enables are 0. The MEM/WB write-back still completes this cycle.
     - Next state is HALTED.
  2. **Memory wait** (dmem_req_EX_MEM & !dhit)
     - All enables are 0 and pc_en is 0.
     - Next state is DWAIT.
  3. **Redirect** (redirect_EX_MEM)
     - pc_en=1.
     - flush_IF_ID, flush_ID_EX and flush_EX_MEM are all 1.
     - flush_cnt increments. The redirect is taken regardless of ihit.
  4. **Load-use** (load_ID_EX & reg_dest_ID_EX≠0 & (reg_dest_ID_EX==rs_IF_ID | (uses_rt_IF_ID & reg_dest_ID_EX==rt_IF_ID)))
     - pc_en=0 and en_IF_ID=0.
     - flush_ID_EX=1. EX/MEM and MEM/WB advance.
  5. **Fetch miss** (!ihit)
     - pc_en=0 and flush_IF_ID=1. The downstream latches advance.
- DWAIT: all enables are 0 while !dhit.
  - When dhit=1: the outputs are the RUN evaluation with the memory-wait rule suppressed for that cycle. Next state is RUN.
  - halt_MEM_WB is ignored in DWAIT. It cannot occur, because MEM/WB is frozen.
- HALTED:
  - All enables are 0 and halt=1.
  - The state is absorbing until RST.
  - The counters hold their values.
- RST=1:
  - pc_en=0, all enables are 0, all flushes are 1.
  - State becomes RUN, halt=0, and both counters are 0 after the edge.
  - Reset mid-stall (for example in DWAIT) abandons the access with no special handling.
- Counters wrap modulo 2^CNT_W.
  - stall_cnt increments on each cycle that is not in reset, not in HALTED, and has pc_en=0. This includes the halt-detect cycle.

## Timing
- Enables and flushes are combinational from the state and the current inputs, valid in the same cycle. They have no registered latency.
- Load-use always costs exactly one bubble. After the flush, load_ID_EX=0, so the hazard cannot re-detect.
- Redirect costs three flushed slots and takes effect at the same edge the PC loads the target.
- If a redirect and a memory wait arrive together, the memory wait wins. The redirect is re-evaluated when dhit arrives, because EX/MEM is still holding it.
- If a redirect and a load-use hazard arrive together, the redirect wins. The flush removes the dependent instruction.
- halt rises the cycle after halt_MEM_WB is sampled, then stays high.
- State and counters update on the rising edge of CLK.

## Structure
- Place the ctrl_state_t enum (RUN, DWAIT, HALTED) in data_path_muxs_pkg.
- Opcode decoding for load_ID_EX and dmem_req_EX_MEM stays upstream, using cpu_types_pkg opcodes.
- One sub-module is natural: perf_counter (CNT_W-wide, synchronous clear, enable-gated increment). It is instantiated twice.

## Test plan
- **Reset:** hold RST for 2 cycles → pc_en=0, all flushes=1, halt=0, stall_cnt=0, flush_cnt=0.
- **Load-use:** load_ID_EX=1, reg_dest_ID_EX=5, rs_IF_ID=5, ihit=1 → one cycle with pc_en=0, en_IF_ID=0, flush_ID_EX=1. The next cycle is all-enable, and stall_cnt=1.
- **Load-use on $0:** reg_dest_ID_EX=0 and rs_IF_ID=0 → no stall.
- **Rt not read:** rt match with uses_rt_IF_ID=0 → no stall.
- **Memory wait then redirect:** dmem_req_EX_MEM=1, dhit=0 for 3 cycles, with redirect_EX_MEM=1 → all enables 0 in every waiting cycle (RUN→DWAIT). When dhit=1: the three flushes assert, pc_en=1, flush_cnt=1, and stall_cnt=3.
- **Fetch miss:** ihit=0 for 2 cycles → flush_IF_ID=1 and pc_en=0 in both cycles, en_EX_MEM=1 throughout.
- **Halt:** halt_MEM_WB=1 → the next cycle halt=1 and all enables stay 0 for 10 cycles despite ihit/redirect toggling. Counters stop advancing after the halt-detect cycle. Pulsing RST returns the block to RUN.
